// File: rtl/entity_collision_scanner_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared definitions for the entity collision scanner and related collision
// logic: FSM state encoding, default playfield size and default character
// box size.
// -----------------------------------------------------------------------------
package collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  localparam int CHAR_W = 32;
  localparam int CHAR_H = 48;

endpackage

// File: rtl/entity_collision_scanner_if.sv
// -----------------------------------------------------------------------------
// entity_collision_scanner_if
// Request/response handshake bundle for the collision scanner.
//   req_valid/req_ready : request handshake (caller -> scanner)
//   req_id              : index of the entity being moved
//   req_x/req_y         : proposed top-left position
//   req_full            : 1 = scan all entities, 0 = stop at first hit / oob
//   rsp_valid/rsp_ready : response handshake (scanner -> caller)
//   rsp_allowed         : move is legal
//   rsp_oob             : proposed box leaves the playfield
//   rsp_hit_mask        : colliding entities found by the scan
//   rsp_first_hit       : lowest colliding index, 0 if none
// Modports: master = movement controller, slave = scanner.
// -----------------------------------------------------------------------------
interface entity_collision_scanner_if #(
  parameter int N_ENT   = 4,
  parameter int ID_W    = 2,
  parameter int COORD_W = 10
);

  logic               req_valid;
  logic               req_ready;
  logic [ID_W-1:0]    req_id;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               req_full;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_allowed;
  logic               rsp_oob;
  logic [N_ENT-1:0]   rsp_hit_mask;
  logic [ID_W-1:0]    rsp_first_hit;

  modport master (
    output req_valid, req_id, req_x, req_y, req_full, rsp_ready,
    input  req_ready, rsp_valid, rsp_allowed, rsp_oob, rsp_hit_mask, rsp_first_hit
  );

  modport slave (
    input  req_valid, req_id, req_x, req_y, req_full, rsp_ready,
    output req_ready, rsp_valid, rsp_allowed, rsp_oob, rsp_hit_mask, rsp_first_hit
  );

endinterface

// File: rtl/entity_collision_scanner_aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
// Purely combinational strict axis-aligned box overlap test. Boxes that only
// share an edge do not overlap. End coordinates are formed one bit wider than
// the coordinates so a box near the top of the coordinate range never wraps.
//   ax, ay, aw, ah : box A top-left and size
//   bx, by, bw, bh : box B top-left and size
//   overlap        : 1 when the interiors intersect
// -----------------------------------------------------------------------------
module aabb_overlap #(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 7
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [SIZE_W-1:0]  aw,
  input  logic [SIZE_W-1:0]  ah,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [SIZE_W-1:0]  bw,
  input  logic [SIZE_W-1:0]  bh,
  output logic               overlap
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0] ax_s, ay_s, bx_s, by_s;
  logic [EW-1:0] ax_e, ay_e, bx_e, by_e;

  assign ax_s = {1'b0, ax};
  assign ay_s = {1'b0, ay};
  assign bx_s = {1'b0, bx};
  assign by_s = {1'b0, by};

  assign ax_e = ax_s + EW'(aw);
  assign ay_e = ay_s + EW'(ah);
  assign bx_e = bx_s + EW'(bw);
  assign by_e = by_s + EW'(bh);

  assign overlap = (ax_s < bx_e) && (ax_e > bx_s) &&
                   (ay_s < by_e) && (ay_e > by_s);

endmodule

// File: rtl/entity_collision_scanner.sv
// -----------------------------------------------------------------------------
// entity_collision_scanner
// Sequential move-legality checker. A proposed top-left position for one
// entity is compared against every other active entity, one per clock, and
// against the playfield bounds. The result is returned over a valid/ready
// handshake and held until taken.
//   clk, reset           : clock, asynchronous active-high reset
//   ent_x/ent_y          : packed positions, entity i at [i*COORD_W +: COORD_W]
//   ent_w/ent_h          : packed sizes, entity i at [i*SIZE_W +: SIZE_W]
//   ent_active           : entity takes part in collision
//   bus (slave)          : request/response handshake
//
// state | meaning
// IDLE  | ready for a request, last result still visible on rsp_*
// SCAN  | test entity idx this cycle; bounds registered on idx 0
// RESP  | rsp_valid high, result frozen until rsp_ready
// -----------------------------------------------------------------------------
module entity_collision_scanner
  import collision_pkg::*;
#(
  parameter int N_ENT    = 4,
  parameter int ID_W     = 2,
  parameter int COORD_W  = 10,
  parameter int SIZE_W   = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_ENT*COORD_W-1:0] ent_x,
  input  logic [N_ENT*COORD_W-1:0] ent_y,
  input  logic [N_ENT*SIZE_W-1:0]  ent_w,
  input  logic [N_ENT*SIZE_W-1:0]  ent_h,
  input  logic [N_ENT-1:0]         ent_active,
  entity_collision_scanner_if.slave bus
);

  localparam int EW = COORD_W + 1;
  localparam logic [EW-1:0]   SCR_W_L  = EW'(SCREEN_W);
  localparam logic [EW-1:0]   SCR_H_L  = EW'(SCREEN_H);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_ENT - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    first_q, first_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [SIZE_W-1:0]  w_q, w_d;
  logic [SIZE_W-1:0]  h_q, h_d;
  logic               full_q, full_d;
  logic               oob_q, oob_d;
  logic [N_ENT-1:0]   mask_q, mask_d;

  logic [COORD_W-1:0] cand_x, cand_y;
  logic [SIZE_W-1:0]  cand_w, cand_h;
  logic               cand_act;
  logic [SIZE_W-1:0]  mover_w, mover_h;
  logic               ovl;
  logic               hit_now;
  logic               oob_calc;
  logic               oob_now;
  logic [EW-1:0]      x_end, y_end;

  // Candidate entity for this scan step, and the mover's own size at the
  // requested index. An out-of-range req_id matches no entry, so its size
  // stays 0 and it can never overlap anything.
  always_comb begin
    cand_x   = '0;
    cand_y   = '0;
    cand_w   = '0;
    cand_h   = '0;
    cand_act = 1'b0;
    mover_w  = '0;
    mover_h  = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (idx_q == ID_W'(i)) begin
        cand_x   = ent_x[i*COORD_W +: COORD_W];
        cand_y   = ent_y[i*COORD_W +: COORD_W];
        cand_w   = ent_w[i*SIZE_W +: SIZE_W];
        cand_h   = ent_h[i*SIZE_W +: SIZE_W];
        cand_act = ent_active[i];
      end
      if (bus.req_id == ID_W'(i)) begin
        mover_w = ent_w[i*SIZE_W +: SIZE_W];
        mover_h = ent_h[i*SIZE_W +: SIZE_W];
      end
    end
  end

  aabb_overlap #(
    .COORD_W (COORD_W),
    .SIZE_W  (SIZE_W)
  ) u_overlap (
    .ax      (x_q),
    .ay      (y_q),
    .aw      (w_q),
    .ah      (h_q),
    .bx      (cand_x),
    .by      (cand_y),
    .bw      (cand_w),
    .bh      (cand_h),
    .overlap (ovl)
  );

  assign x_end    = {1'b0, x_q} + EW'(w_q);
  assign y_end    = {1'b0, y_q} + EW'(h_q);
  assign oob_calc = (x_end > SCR_W_L) || (y_end > SCR_H_L);

  // Self-skip compares against the latched id, so an inactive mover is still
  // checked and an out-of-range id skips nothing.
  assign hit_now = (state_q == ST_SCAN) && cand_act && (idx_q != id_q) && ovl;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    id_d    = id_q;
    first_d = first_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    full_d  = full_q;
    oob_d   = oob_q;
    mask_d  = mask_q;
    oob_now = oob_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          id_d    = bus.req_id;
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          full_d  = bus.req_full;
          w_d     = mover_w;
          h_d     = mover_h;
          mask_d  = '0;
          first_d = '0;
          oob_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (idx_q == '0) begin
          oob_d   = oob_calc;
          oob_now = oob_calc;
        end
        if (hit_now) begin
          for (int i = 0; i < N_ENT; i++) begin
            if (idx_q == ID_W'(i)) mask_d[i] = 1'b1;
          end
          if (mask_q == '0) first_d = idx_q;
        end
        if ((idx_q == LAST_IDX) || (!full_q && (hit_now || oob_now))) begin
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      first_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      full_q  <= 1'b0;
      oob_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      first_q <= first_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      full_q  <= full_d;
      oob_q   <= oob_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.rsp_allowed   = !oob_q && (mask_q == '0);
  assign bus.rsp_oob       = oob_q;
  assign bus.rsp_hit_mask  = mask_q;
  assign bus.rsp_first_hit = first_q;

endmodule

// File: tb/tb_entity_collision_scanner.sv
// -----------------------------------------------------------------------------
// tb_entity_collision_scanner
// Table-driven bench for the collision scanner with a response scoreboard,
// plus hand-written back-pressure and reset-mid-scan sequences.
// -----------------------------------------------------------------------------
module tb_entity_collision_scanner;
  import collision_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 10;
  localparam int SW  = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*CW-1:0] ent_x, ent_y;
  logic [N*SW-1:0] ent_w, ent_h;
  logic [N-1:0]    ent_active;

  int n_chk = 0;
  int n_err = 0;

  entity_collision_scanner_if #(.N_ENT(N), .ID_W(IDW), .COORD_W(CW)) bus ();

  entity_collision_scanner #(
    .N_ENT    (N),
    .ID_W     (IDW),
    .COORD_W  (CW),
    .SIZE_W   (SW),
    .SCREEN_W (640),
    .SCREEN_H (480)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ent_x      (ent_x),
    .ent_y      (ent_y),
    .ent_w      (ent_w),
    .ent_h      (ent_h),
    .ent_active (ent_active),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*CW-1:0] xs;
    logic [N*CW-1:0] ys;
    logic [N-1:0]    act;
    logic [IDW-1:0]  id;
    logic [CW-1:0]   rx;
    logic [CW-1:0]   ry;
    logic            full;
    logic [SW-1:0]   mw;
    logic [SW-1:0]   mh;
    logic            e_allowed;
    logic            e_oob;
    logic [N-1:0]    e_mask;
    logic [IDW-1:0]  e_first;
    int              e_lat;
  } vec_t;

  typedef struct {
    logic           allowed;
    logic           oob;
    logic [N-1:0]   mask;
    logic [IDW-1:0] first;
    int             lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic [N*CW-1:0] p4(int a0, int a1, int a2, int a3);
    return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
  endfunction

  function automatic vec_t mk(int x0, int y0, int x1, int y1, int x2, int y2,
                              int x3, int y3, logic [3:0] act, int id,
                              int rx, int ry, logic full, int mw, int mh,
                              logic ea, logic eo, logic [3:0] em, int ef, int el);
    vec_t v;
    v.xs = p4(x0, x1, x2, x3);
    v.ys = p4(y0, y1, y2, y3);
    v.act = act;
    v.id = IDW'(id);
    v.rx = CW'(rx);
    v.ry = CW'(ry);
    v.full = full;
    v.mw = SW'(mw);
    v.mh = SW'(mh);
    v.e_allowed = ea;
    v.e_oob = eo;
    v.e_mask = em;
    v.e_first = IDW'(ef);
    v.e_lat = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_ent(input vec_t v);
    ent_x = v.xs;
    ent_y = v.ys;
    ent_active = v.act;
    for (int i = 0; i < N; i++) begin
      ent_w[i*SW +: SW] = (i == int'(v.id)) ? v.mw : SW'(CHAR_W);
      ent_h[i*SW +: SW] = (i == int'(v.id)) ? v.mh : SW'(CHAR_H);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name, input logic bp);
    exp_t e;
    exp_t got;
    int cnt;
    drive_ent(v);
    bus.req_id = v.id;
    bus.req_x = v.rx;
    bus.req_y = v.ry;
    bus.req_full = v.full;
    bus.rsp_ready = !bp;
    chk({name, "/req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    e.allowed = v.e_allowed;
    e.oob = v.e_oob;
    e.mask = v.e_mask;
    e.first = v.e_first;
    e.lat = v.e_lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    cnt = 0;
    while (!bus.rsp_valid && cnt < 64) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    got = sb.pop_front();
    if (!bus.rsp_valid) begin
      n_chk++;
      n_err++;
      $display("FAIL %s/timeout: no rsp_valid within %0d cycles", name, cnt);
      bus.rsp_ready = 1'b1;
      return;
    end
    chk({name, "/latency"}, 32'(cnt), 32'(got.lat));
    chk({name, "/allowed"}, 32'(bus.rsp_allowed), 32'(got.allowed));
    chk({name, "/oob"}, 32'(bus.rsp_oob), 32'(got.oob));
    chk({name, "/mask"}, 32'(bus.rsp_hit_mask), 32'(got.mask));
    chk({name, "/first_hit"}, 32'(bus.rsp_first_hit), 32'(got.first));
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        chk({name, "/bp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({name, "/bp_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({name, "/bp_stable"},
            32'({bus.rsp_allowed, bus.rsp_oob, bus.rsp_hit_mask, bus.rsp_first_hit}),
            32'({got.allowed, got.oob, got.mask, got.first}));
      end
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({name, "/rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, "/req_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_id = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_full = 1'b1;
    bus.rsp_ready = 1'b1;
    ent_x = '0;
    ent_y = '0;
    ent_w = '0;
    ent_h = '0;
    ent_active = '1;

    // Clear move, multi-hit, early exit
    vecs.push_back(mk(0,0, 100,0, 200,0, 300,0, 4'b1111, 0, 40,100, 1, 32,48, 1,0,4'b0000,0,4));
    vecs.push_back(mk(0,0, 50,50, 300,300, 50,50, 4'b1111, 0, 60,60, 1, 32,48, 0,0,4'b1010,1,4));
    vecs.push_back(mk(0,0, 50,50, 300,300, 50,50, 4'b1111, 0, 60,60, 0, 32,48, 0,0,4'b0010,1,2));
    // Edge touch in x, one-pixel overlap, edge touch in y
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 68,0, 1, 32,48, 1,0,4'b0000,0,4));
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 69,0, 1, 32,48, 0,0,4'b0010,1,4));
    vecs.push_back(mk(0,0, 0,100, 200,200, 300,300, 4'b1111, 0, 0,52, 1, 32,48, 1,0,4'b0000,0,4));
    // Out of bounds: x full, x early, y full, exact fit
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 620,0, 1, 32,48, 0,1,4'b0000,0,4));
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 620,0, 0, 32,48, 0,1,4'b0000,0,1));
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 0,440, 1, 32,48, 0,1,4'b0000,0,4));
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 608,432, 1, 32,48, 1,0,4'b0000,0,4));
    // Entity near top of coordinate range: no false hit, and a real hit past 1023
    vecs.push_back(mk(0,0, 1000,0, 200,200, 300,300, 4'b1111, 0, 0,0, 1, 32,48, 1,0,4'b0000,0,4));
    vecs.push_back(mk(0,0, 1000,0, 200,200, 300,300, 4'b1111, 0, 1010,0, 1, 32,48, 0,1,4'b0010,1,4));
    // Self-skip, inactive entity, inactive mover
    vecs.push_back(mk(0,0, 100,0, 200,0, 300,0, 4'b1111, 2, 200,0, 1, 32,48, 1,0,4'b0000,0,4));
    vecs.push_back(mk(0,0, 50,50, 300,300, 400,300, 4'b1101, 0, 60,60, 1, 32,48, 1,0,4'b0000,0,4));
    vecs.push_back(mk(0,0, 50,50, 300,300, 400,300, 4'b1110, 0, 60,60, 1, 32,48, 0,0,4'b0010,1,4));
    // Early exit on last index, early exit on index 0, small mover, multi-hit with first=0
    vecs.push_back(mk(0,0, 300,0, 300,300, 50,50, 4'b1111, 0, 60,60, 0, 32,48, 0,0,4'b1000,3,4));
    vecs.push_back(mk(50,50, 300,0, 300,300, 500,400, 4'b1111, 3, 60,60, 0, 32,48, 0,0,4'b0001,0,1));
    vecs.push_back(mk(0,0, 100,0, 200,200, 300,300, 4'b1111, 0, 92,0, 1, 8,8, 1,0,4'b0000,0,4));
    vecs.push_back(mk(60,60, 0,0, 300,300, 70,70, 4'b1111, 1, 60,60, 1, 32,48, 0,0,4'b1001,0,4));

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset/req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset/allowed", 32'(bus.rsp_allowed), 32'd1);
    chk("reset/oob", 32'(bus.rsp_oob), 32'd0);
    chk("reset/mask", 32'(bus.rsp_hit_mask), 32'd0);
    chk("reset/first_hit", 32'(bus.rsp_first_hit), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i), 1'b0);
    end

    run_vec(vecs[1], "backpressure", 1'b1);

    // Reset asserted during the second SCAN cycle
    drive_ent(vecs[0]);
    bus.req_id = vecs[0].id;
    bus.req_x = vecs[0].rx;
    bus.req_y = vecs[0].ry;
    bus.req_full = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midscan/busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midscan/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midscan/req_ready", 32'(bus.req_ready), 32'd1);
    chk("midscan/mask", 32'(bus.rsp_hit_mask), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[1], "after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
